// File: rtl/hamming_secded_if.sv
// Valid/ready stream bundle for the Hamming(8,4) SECDED decoder.
// The slave side is the decoder; the master side feeds codewords and takes results.
interface hamming_secded_if;
    logic [7:0] in_code;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_data;
    logic       out_corrected;
    logic       out_double;
    logic [2:0] out_err_pos;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output in_code, in_valid, out_ready,
        input  in_ready, out_data, out_corrected, out_double, out_err_pos, out_valid
    );

    modport slave (
        input  in_code, in_valid, out_ready,
        output in_ready, out_data, out_corrected, out_double, out_err_pos, out_valid
    );
endinterface

// File: rtl/hamming_secded_decoder.sv
// Streaming Hamming(8,4) SECDED decoder: a syndrome stage and a correct/classify
// output stage, plus saturating corrected/double-error counters.
module hamming_secded_decoder (
    input  logic                   clk,
    input  logic                   rst,
    hamming_secded_if.slave        bus,
    input  logic                   clr_counts,
    output logic [7:0]             corr_count,
    output logic [7:0]             dbl_count
);

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_SINGLE,
        ERR_PARITY,
        ERR_DOUBLE
    } err_class_e;

    logic       w_adv1;
    logic       w_adv2;
    logic       w_out_fire;

    logic       r_s1_valid;
    logic [7:0] r_s1_code;

    logic [2:0] w_syn;
    logic       w_par;
    err_class_e w_class;
    logic [7:0] w_fixed;
    logic [3:0] w_data;
    logic       w_corrected;
    logic       w_double;
    logic [2:0] w_err_pos;

    logic       r_out_valid;
    logic [3:0] r_out_data;
    logic       r_out_corrected;
    logic       r_out_double;
    logic [2:0] r_out_err_pos;

    logic [7:0] r_corr_count;
    logic [7:0] r_dbl_count;

    // Output stage advances when empty or drained; stage 1 advances when empty or
    // when it can hand its word to the output stage.
    assign w_adv2       = !r_out_valid || bus.out_ready;
    assign w_adv1       = !r_s1_valid || w_adv2;
    assign bus.in_ready = w_adv1 && !rst;
    assign w_out_fire   = r_out_valid && bus.out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= 8'h00;
        end else if (w_adv1) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_code <= bus.in_code;
            end
        end
    end

    // Parity-check masks: s1 covers c1,c3,c5,c7; s2 covers c2,c3,c6,c7; s4 covers c4..c7.
    assign w_syn = {^(r_s1_code & 8'hF0), ^(r_s1_code & 8'hCC), ^(r_s1_code & 8'hAA)};
    assign w_par = ^r_s1_code;

    always_comb begin
        if (w_syn == 3'd0) begin
            w_class = w_par ? ERR_PARITY : ERR_NONE;
        end else begin
            w_class = w_par ? ERR_SINGLE : ERR_DOUBLE;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_fixed     = r_s1_code;
        w_corrected = 1'b0;
        w_double    = 1'b0;
        w_err_pos   = w_syn;
        unique case (w_class)
            ERR_NONE: begin
                w_err_pos = 3'd0;
            end
            ERR_SINGLE: begin
                w_fixed     = r_s1_code ^ (8'd1 << w_syn);
                w_corrected = 1'b1;
            end
            ERR_PARITY: begin
                // Only the overall parity bit flipped; data bits are intact.
                w_corrected = 1'b1;
                w_err_pos   = 3'd0;
            end
            ERR_DOUBLE: begin
                w_double = 1'b1;
            end
            default: begin
                w_fixed = r_s1_code;
            end
        endcase
    end

    assign w_data = {w_fixed[7], w_fixed[6], w_fixed[5], w_fixed[3]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid     <= 1'b0;
            r_out_data      <= 4'h0;
            r_out_corrected <= 1'b0;
            r_out_double    <= 1'b0;
            r_out_err_pos   <= 3'd0;
        end else if (w_adv2) begin
            r_out_valid     <= r_s1_valid;
            r_out_data      <= w_data;
            r_out_corrected <= w_corrected;
            r_out_double    <= w_double;
            r_out_err_pos   <= w_err_pos;
        end
    end

    // Clear has priority over a coincident increment.
    always_ff @(posedge clk) begin
        if (rst || clr_counts) begin
            r_corr_count <= 8'd0;
            r_dbl_count  <= 8'd0;
        end else if (w_out_fire) begin
            if (r_out_corrected && (r_corr_count != 8'hFF)) begin
                r_corr_count <= r_corr_count + 8'd1;
            end
            if (r_out_double && (r_dbl_count != 8'hFF)) begin
                r_dbl_count <= r_dbl_count + 8'd1;
            end
        end
    end

    assign bus.out_valid     = r_out_valid;
    assign bus.out_data      = r_out_data;
    assign bus.out_corrected = r_out_corrected;
    assign bus.out_double    = r_out_double;
    assign bus.out_err_pos   = r_out_err_pos;
    assign corr_count        = r_corr_count;
    assign dbl_count         = r_dbl_count;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Self-checking bench for hamming_secded_decoder: directed scenarios plus a
// randomized stream scored against an error-injection reference model.
module tb_hamming_secded_decoder;

    typedef struct packed {
        logic       valid;
        logic [3:0] data;
        logic       corr;
        logic       dbl;
        logic [2:0] pos;
    } obs_t;

    logic       clk;
    logic       rst;
    logic       clr_counts;
    logic [7:0] corr_count;
    logic [7:0] dbl_count;

    int n_tests;
    int n_fail;

    hamming_secded_if bus ();

    hamming_secded_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clr_counts (clr_counts),
        .corr_count (corr_count),
        .dbl_count  (dbl_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic obs_t sample();
        obs_t o;
        o.valid = bus.out_valid;
        o.data  = bus.out_data;
        o.corr  = bus.out_corrected;
        o.dbl   = bus.out_double;
        o.pos   = bus.out_err_pos;
        return o;
    endfunction

    function automatic obs_t mk(input logic v, input logic [3:0] d, input logic c,
                                input logic b, input logic [2:0] p);
        obs_t o;
        o.valid = v; o.data = d; o.corr = c; o.dbl = b; o.pos = p;
        return o;
    endfunction

    // Encoder from the codeword layout: data in c3,c5,c6,c7; p1/p2/p4 cover the
    // positions whose index has that bit set; c0 makes overall parity even.
    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [7:0] c;
        int ones;
        c = 8'h00;
        c[3] = d[0]; c[5] = d[1]; c[6] = d[2]; c[7] = d[3];
        for (int k = 1; k < 8; k++) begin
            if (k != 3 && k != 5 && k != 6 && k != 7) begin
                for (int m = 3; m < 8; m++) begin
                    if ((m & k) != 0 && m != 4) c[k] = c[k] ^ c[m];
                end
            end
        end
        ones = 0;
        for (int k = 1; k < 8; k++) ones += c[k];
        c[0] = logic'(ones % 2);
        return c;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bus.in_valid = 1'b0; clr_counts = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Push one codeword into an empty pipeline with out_ready=1; returns outputs
    // just after the accept edge and just after the following edge, then lets
    // the handshake complete.
    task automatic xfer(input logic [7:0] code, output obs_t early, output obs_t late);
        @(negedge clk);
        bus.in_code = code; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        early = sample();
        @(posedge clk); #1;
        late = sample();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        obs_t o;
        repeat (2) @(negedge clk);
        o = sample();
        n_tests++;
        if ({o, corr_count, dbl_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 0", {o, corr_count, dbl_count});
        end
        n_tests++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL first_cycle_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_clean();
        obs_t e, l;
        xfer(8'hAA, e, l);
        n_tests++;
        if (e.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_latency: out_valid got %b expected 0 one edge after accept", e.valid);
        end
        n_tests++;
        if (l !== mk(1'b1, 4'hB, 1'b0, 1'b0, 3'd0)) begin
            n_fail++;
            $display("FAIL clean_word: got %h expected %h", l, mk(1'b1, 4'hB, 1'b0, 1'b0, 3'd0));
        end
        n_tests++;
        if ({corr_count, dbl_count} !== 16'h0000) begin
            n_fail++;
            $display("FAIL clean_counts: got %h expected 0000", {corr_count, dbl_count});
        end
    endtask

    task automatic test_single();
        obs_t e, l;
        xfer(8'h8A, e, l);
        n_tests++;
        if (l !== mk(1'b1, 4'hB, 1'b1, 1'b0, 3'd5)) begin
            n_fail++;
            $display("FAIL single_c5: got %h expected %h", l, mk(1'b1, 4'hB, 1'b1, 1'b0, 3'd5));
        end
        n_tests++;
        if (corr_count !== 8'd1) begin
            n_fail++;
            $display("FAIL single_c5_count: got %0d expected 1", corr_count);
        end
        xfer(8'hAB, e, l);
        n_tests++;
        if (l !== mk(1'b1, 4'hB, 1'b1, 1'b0, 3'd0)) begin
            n_fail++;
            $display("FAIL single_c0: got %h expected %h", l, mk(1'b1, 4'hB, 1'b1, 1'b0, 3'd0));
        end
        n_tests++;
        if ({corr_count, dbl_count} !== {8'd2, 8'd0}) begin
            n_fail++;
            $display("FAIL single_c0_count: got %h expected 0200", {corr_count, dbl_count});
        end
    endtask

    task automatic test_double();
        obs_t e, l;
        xfer(8'hAC, e, l);
        n_tests++;
        if (l !== mk(1'b1, 4'hB, 1'b0, 1'b1, 3'd3)) begin
            n_fail++;
            $display("FAIL double: got %h expected %h", l, mk(1'b1, 4'hB, 1'b0, 1'b1, 3'd3));
        end
        n_tests++;
        if ({corr_count, dbl_count} !== {8'd2, 8'd1}) begin
            n_fail++;
            $display("FAIL double_count: got %h expected 0201", {corr_count, dbl_count});
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        do_reset();
        bus.out_ready = 1'b0;
        @(negedge clk); bus.in_code = 8'hAA; bus.in_valid = 1'b1;
        @(negedge clk); bus.in_code = 8'h8A;
        @(negedge clk); bus.in_code = 8'hAC;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full_ready: got %b expected 0", bus.in_ready);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            o = sample();
            n_tests++;
            if ({o, bus.in_ready} !== {mk(1'b1, 4'hB, 1'b0, 1'b0, 3'd0), 1'b0}) begin
                n_fail++;
                $display("FAIL bp_stall_%0d: got %h expected %h", k, {o, bus.in_ready},
                         {mk(1'b1, 4'hB, 1'b0, 1'b0, 3'd0), 1'b0});
            end
        end
        @(negedge clk); bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        o = sample();
        n_tests++;
        if (o !== mk(1'b1, 4'hB, 1'b1, 1'b0, 3'd5)) begin
            n_fail++;
            $display("FAIL bp_order_2: got %h expected %h", o, mk(1'b1, 4'hB, 1'b1, 1'b0, 3'd5));
        end
        @(posedge clk); #1;
        o = sample();
        n_tests++;
        if (o !== mk(1'b1, 4'hB, 1'b0, 1'b1, 3'd3)) begin
            n_fail++;
            $display("FAIL bp_order_3: got %h expected %h", o, mk(1'b1, 4'hB, 1'b0, 1'b1, 3'd3));
        end
        @(posedge clk); #1;
        n_tests++;
        if ({bus.out_valid, corr_count, dbl_count} !== {1'b0, 8'd1, 8'd1}) begin
            n_fail++;
            $display("FAIL bp_drain: got %h expected 00101", {bus.out_valid, corr_count, dbl_count});
        end
    endtask

    task automatic test_saturation_clear();
        obs_t e, l;
        do_reset();
        bus.out_ready = 1'b1;
        @(negedge clk); bus.in_code = 8'h8A; bus.in_valid = 1'b1;
        repeat (256) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({corr_count, dbl_count} !== {8'd255, 8'd0}) begin
            n_fail++;
            $display("FAIL saturate: got %h expected ff00", {corr_count, dbl_count});
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); bus.in_code = 8'h8A; bus.in_valid = 1'b1;
            @(posedge clk); #1 bus.in_valid = 1'b0;
            @(posedge clk); #1;
            n_tests++;
            if ({bus.out_valid, bus.out_corrected} !== 2'b11) begin
                n_fail++;
                $display("FAIL clr_setup_%0d: got %b expected 11", k, {bus.out_valid, bus.out_corrected});
            end
            clr_counts = 1'b1;
            @(posedge clk); #1;
            clr_counts = 1'b0;
            n_tests++;
            if (corr_count !== 8'd0) begin
                n_fail++;
                $display("FAIL clr_wins_%0d: got %0d expected 0", k, corr_count);
            end
            if (k == 0) begin
                xfer(8'h8A, e, l);
                n_tests++;
                if (corr_count !== 8'd1) begin
                    n_fail++;
                    $display("FAIL count_after_clr: got %0d expected 1", corr_count);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        obs_t e, l;
        do_reset();
        xfer(8'h8A, e, l);
        xfer(8'hAC, e, l);
        bus.out_ready = 1'b0;
        @(negedge clk); bus.in_code = 8'hAA; bus.in_valid = 1'b1;
        @(negedge clk); bus.in_code = 8'h8A;
        @(negedge clk); bus.in_valid = 1'b0;
        #1;
        n_tests++;
        if ({bus.out_valid, bus.in_ready, corr_count, dbl_count} !== {1'b1, 1'b0, 8'd1, 8'd1}) begin
            n_fail++;
            $display("FAIL rst_mid_setup: got %h expected 20101", {bus.out_valid, bus.in_ready, corr_count, dbl_count});
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_ready: got %b expected 0", bus.in_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if ({sample(), corr_count, dbl_count, bus.in_ready} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_flush: got %h expected 0", {sample(), corr_count, dbl_count, bus.in_ready});
        end
        @(negedge clk); rst = 1'b0;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_release: got %b expected 1", bus.in_ready);
        end
        xfer(8'hAA, e, l);
        n_tests++;
        if ({e.valid, l} !== {1'b0, mk(1'b1, 4'hB, 1'b0, 1'b0, 3'd0)}) begin
            n_fail++;
            $display("FAIL rst_mid_after: got %h expected %h", {e.valid, l}, {1'b0, mk(1'b1, 4'hB, 1'b0, 1'b0, 3'd0)});
        end
    endtask

    // Expected result follows from how many bits were flipped and where.
    task automatic test_random();
        obs_t q[$];
        obs_t exp_new, exp_out, snap, o;
        logic [7:0] code;
        logic [3:0] d;
        int nflip, bi, bj;
        int corr_m, dbl_m;
        logic stalled, in_fire, out_fire;
        do_reset();
        corr_m = 0; dbl_m = 0; stalled = 1'b0; snap = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            n_tests++;
            if ({corr_count, dbl_count} !== {8'(corr_m), 8'(dbl_m)}) begin
                n_fail++;
                $display("FAIL rand_counts cyc %0d: got %h expected %h", cyc, {corr_count, dbl_count}, {8'(corr_m), 8'(dbl_m)});
            end
            if (stalled) begin
                o = sample();
                n_tests++;
                if (o !== snap) begin
                    n_fail++;
                    $display("FAIL rand_stable cyc %0d: got %h expected %h", cyc, o, snap);
                end
            end
            if (cyc < 2980) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
                clr_counts    = ($urandom_range(0, 63) == 0);
                bus.in_valid  = ($urandom_range(0, 3) != 0);
            end else begin
                bus.out_ready = 1'b1;
                clr_counts    = 1'b0;
                bus.in_valid  = 1'b0;
            end
            d = 4'($urandom_range(0, 15));
            nflip = $urandom_range(0, 2);
            bi = $urandom_range(0, 7);
            bj = (bi + $urandom_range(1, 7)) % 8;
            code = encode(d);
            if (nflip >= 1) code[bi] = ~code[bi];
            if (nflip == 2) code[bj] = ~code[bj];
            case (nflip)
                0: exp_new = mk(1'b1, d, 1'b0, 1'b0, 3'd0);
                1: exp_new = mk(1'b1, d, 1'b1, 1'b0, 3'(bi));
                default: exp_new = mk(1'b1, {code[7], code[6], code[5], code[3]}, 1'b0, 1'b1, 3'(bi ^ bj));
            endcase
            bus.in_code = code;
            #1;
            in_fire  = bus.in_valid && bus.in_ready;
            out_fire = bus.out_valid && bus.out_ready;
            if (out_fire) begin
                o = sample();
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra cyc %0d: got %h expected no output", cyc, o);
                end else begin
                    exp_out = q.pop_front();
                    if (o !== exp_out) begin
                        n_fail++;
                        $display("FAIL rand_word cyc %0d: got %h expected %h", cyc, o, exp_out);
                    end
                    if (exp_out.corr && corr_m < 255) corr_m++;
                    if (exp_out.dbl && dbl_m < 255) dbl_m++;
                end
            end
            if (clr_counts) begin
                corr_m = 0; dbl_m = 0;
            end
            if (in_fire) q.push_back(exp_new);
            stalled = bus.out_valid && !bus.out_ready;
            snap = sample();
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_drain: got %0d words pending expected 0", q.size());
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        clr_counts = 1'b0;
        bus.in_code = 8'h00;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_clean();
        test_single();
        test_double();
        test_backpressure();
        test_saturation_clear();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
